// File: rtl/sorcerer_kbd_pkg.sv
// Shared types and constants for the Sorcerer keyboard matrix.
// Optional feature macro used by the top: SORCERER_KBD_RESET_KEY_EN.
package sorcerer_kbd_pkg;

    localparam int KBD_ROWS = 16;
    localparam int KBD_COLS = 5;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_F12    = 8'h07;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        APPLY
    } kbd_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] col;
    } kbd_pos_t;

    typedef struct packed {
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } kbd_evt_t;

    localparam kbd_pos_t KBD_MISS = '{hit: 1'b0, row: 4'd0, col: 3'd0};

    function automatic kbd_pos_t kbd_at(input int unsigned r, input int unsigned c);
        kbd_pos_t p;
        p.hit = 1'b1;
        p.row = 4'(r);
        p.col = 3'(c);
        return p;
    endfunction

endpackage

// File: rtl/sorcerer_kbd_map.sv
// Combinational PS/2 set-2 scancode to Sorcerer matrix position table.
// Codes not listed here (including ext codes without an ext entry) report a miss.
module sorcerer_kbd_map
    import sorcerer_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output kbd_pos_t   pos
);

    always_comb begin
        pos = KBD_MISS;
        case ({ext, code})
            9'h076: pos = kbd_at(0, 0);   // Esc
            9'h014: pos = kbd_at(0, 3);   // Ctrl
            9'h012: pos = kbd_at(0, 4);   // both shifts share one cell
            9'h059: pos = kbd_at(0, 4);
            9'h029: pos = kbd_at(1, 2);   // Space
            9'h01A: pos = kbd_at(2, 4);
            9'h022: pos = kbd_at(2, 3);
            9'h021: pos = kbd_at(3, 4);
            9'h02A: pos = kbd_at(3, 3);
            9'h032: pos = kbd_at(4, 4);
            9'h031: pos = kbd_at(4, 3);
            9'h03A: pos = kbd_at(5, 4);
            9'h015: pos = kbd_at(5, 3);
            9'h01D: pos = kbd_at(6, 4);
            9'h024: pos = kbd_at(6, 3);
            9'h02D: pos = kbd_at(7, 4);
            9'h02C: pos = kbd_at(7, 3);
            9'h035: pos = kbd_at(8, 4);
            9'h03C: pos = kbd_at(8, 3);
            9'h01C: pos = kbd_at(9, 4);   // A
            9'h01B: pos = kbd_at(9, 3);
            9'h023: pos = kbd_at(9, 2);
            9'h02B: pos = kbd_at(10, 4);
            9'h034: pos = kbd_at(10, 3);
            9'h033: pos = kbd_at(11, 4);
            9'h03B: pos = kbd_at(11, 3);
            9'h042: pos = kbd_at(12, 4);
            9'h04B: pos = kbd_at(12, 3);
            9'h05A: pos = kbd_at(12, 0);  // Enter
            9'h075: pos = kbd_at(13, 4);  // keypad 8
            9'h072: pos = kbd_at(13, 3);  // keypad 2
            9'h045: pos = kbd_at(14, 4);
            9'h016: pos = kbd_at(14, 3);
            9'h175: pos = kbd_at(15, 1);  // cursor keys live behind the E0 prefix
            9'h172: pos = kbd_at(15, 2);
            9'h16B: pos = kbd_at(15, 3);
            9'h174: pos = kbd_at(15, 4);
            default: pos = KBD_MISS;
        endcase
    end

endmodule

// File: rtl/sorcerer_kbd_matrix.sv
// hps_io ps2_key events to Exidy Sorcerer 16x5 active-low keyboard matrix.
// Define SORCERER_KBD_RESET_KEY_EN to enable the F12 reset_req pulse.
module sorcerer_kbd_matrix
    import sorcerer_kbd_pkg::*;
#(
    parameter int ROWS          = KBD_ROWS,
    parameter int COLS          = KBD_COLS,
    parameter int RST_PULSE_LEN = 16
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [10:0]             ps2_key,
    input  logic                    clear_all,
    input  logic [$clog2(ROWS)-1:0] row_sel,
    output logic [COLS-1:0]         col_data,
    output logic                    key_busy,
    output logic                    reset_req
);

    kbd_state_t      state, state_nx;
    logic            strb_q, armed, ev_new;
    kbd_evt_t        ev_in, ev_q, pend_d;
    logic            pend_v;
    kbd_pos_t        map_pos, pos_q;
    logic            take_new, take_pend, store_new, do_apply;
    logic            shift_l, shift_r, shift_l_nx, shift_r_nx;
    logic            is_lshift, is_rshift, cell_val, row_ok;
    logic [COLS-1:0] matrix [ROWS];

    assign ev_in  = kbd_evt_t'(ps2_key[9:0]);
    // armed keeps the first post-reset strobe sample as a reference only
    assign ev_new = armed && (strb_q != ps2_key[10]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            strb_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            strb_q <= ps2_key[10];
            armed  <= 1'b1;
        end
    end

    // Events arriving while busy wait in pend; the newest one wins.
    always_comb begin
        state_nx  = state;
        take_new  = 1'b0;
        take_pend = 1'b0;
        store_new = 1'b0;
        do_apply  = 1'b0;
        if (clear_all) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_v) begin
                        take_pend = 1'b1;
                        store_new = ev_new;
                        state_nx  = LOOKUP;
                    end else if (ev_new) begin
                        take_new = 1'b1;
                        state_nx = LOOKUP;
                    end
                end
                LOOKUP: begin
                    store_new = ev_new;
                    state_nx  = APPLY;
                end
                APPLY: begin
                    store_new = ev_new;
                    do_apply  = 1'b1;
                    state_nx  = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ev_q   <= '0;
            pend_v <= 1'b0;
            pend_d <= '0;
            pos_q  <= KBD_MISS;
        end else begin
            state <= state_nx;
            if (take_pend) ev_q <= pend_d;
            else if (take_new) ev_q <= ev_in;
            if (clear_all) begin
                pend_v <= 1'b0;
            end else if (store_new) begin
                pend_v <= 1'b1;
                pend_d <= ev_in;
            end else if (take_pend) begin
                pend_v <= 1'b0;
            end
            if (state == LOOKUP) pos_q <= map_pos;
        end
    end

    sorcerer_kbd_map u_map (
        .ext  (ev_q.ext),
        .code (ev_q.code),
        .pos  (map_pos)
    );

    assign key_busy = (state == LOOKUP) || (state == APPLY);

    always_comb begin
        is_lshift  = !ev_q.ext && (ev_q.code == SC_LSHIFT);
        is_rshift  = !ev_q.ext && (ev_q.code == SC_RSHIFT);
        shift_l_nx = is_lshift ? ev_q.pressed : shift_l;
        shift_r_nx = is_rshift ? ev_q.pressed : shift_r;
        cell_val   = (is_lshift || is_rshift) ? (shift_l_nx | shift_r_nx) : ev_q.pressed;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++) matrix[r] <= '0;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (clear_all) begin
            for (int r = 0; r < ROWS; r++) matrix[r] <= '0;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (do_apply && pos_q.hit) begin
            shift_l <= shift_l_nx;
            shift_r <= shift_r_nx;
            matrix[pos_q.row][pos_q.col] <= cell_val;
        end
    end

    assign row_ok = int'(row_sel) < ROWS;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) col_data <= '1;
        else          col_data <= row_ok ? ~matrix[row_sel] : '1;
    end

`ifdef SORCERER_KBD_RESET_KEY_EN
    localparam int CNT_W = $clog2(RST_PULSE_LEN + 1);

    logic [CNT_W-1:0] rst_cnt;
    logic             f12_hit;

    // F12 with any shift held is ignored so shifted F12 stays harmless
    assign f12_hit = do_apply && ev_q.pressed && !ev_q.ext && (ev_q.code == SC_F12)
                     && !shift_l && !shift_r;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)              rst_cnt <= '0;
        else if (f12_hit)          rst_cnt <= CNT_W'(RST_PULSE_LEN);
        else if (rst_cnt != '0)    rst_cnt <= rst_cnt - CNT_W'(1);
    end

    assign reset_req = (rst_cnt != '0);
`else
    logic unused_cfg;
    assign unused_cfg = |RST_PULSE_LEN;
    assign reset_req  = 1'b0;
`endif

endmodule
